// File: rtl/ysyx_220066_mul_div_unit.sv
// Iterative RV64M multiply/divide unit: one bit per cycle in CALC, sign fix-up in FIX.
// Operands are reduced to magnitudes at accept; divide-by-zero and signed overflow bypass CALC.
module ysyx_220066_mul_div_unit #(
  parameter int XLEN  = 64,
  parameter int W_EN  = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW  = $clog2(XLEN);
  localparam int WSH = XLEN - 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x, input logic s);
    logic [XLEN-1:0] r;
    r = {XLEN{s & x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d, lo_q, lo_d, b_q, b_d;
  logic             word_q, word_d, div_q, div_d, hi_q, hi_d, rem_q, rem_d;
  logic             neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             req_word, a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]  ext_a, ext_b, mag_a, mag_b, min_neg, fast_res;
  logic [XLEN:0]    mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s, prod_n;
  logic [XLEN-1:0]  mul_r, quo, rmd, fix_raw, fix_res;
  logic [CW-1:0]    cnt_last;

  always_comb begin
    req_word = (W_EN != 0) && op[3] && (op[2] || (op[1:0] == 2'b00));
    a_signed = op[2] ? !op[0] : (op[1:0] != 2'b11);
    b_signed = op[2] ? !op[0] : !op[1];
    ext_a    = req_word ? sext32(src1[31:0], a_signed) : src1;
    ext_b    = req_word ? sext32(src2[31:0], b_signed) : src2;
    neg_a    = a_signed & ext_a[XLEN-1];
    neg_b    = b_signed & ext_b[XLEN-1];
    mag_a    = neg_a ? -ext_a : ext_a;
    mag_b    = neg_b ? -ext_b : ext_b;
    min_neg  = req_word ? ({XLEN{1'b1}} << 31) : ({{(XLEN-1){1'b0}}, 1'b1} << (XLEN-1));
    div_zero = op[2] && (ext_b == '0);
    div_ovf  = op[2] && !op[0] && (ext_a == min_neg) && (&ext_b);
    if (div_zero) fast_res = op[1] ? src1 : '1;
    else          fast_res = op[1] ? '0 : ext_a;
    if (req_word) fast_res = sext32(fast_res[31:0], 1'b1);
  end

  // Datapath for one CALC step and the FIX-stage sign/width correction.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    cnt_last = word_q ? CW'(31) : CW'(XLEN-1);
    prod     = {acc_q, lo_q};
    prod_s   = word_q ? (prod >> WSH) : prod;
    prod_n   = neg_q ? -prod_s : prod_s;
    mul_r    = hi_q ? prod_n[2*XLEN-1:XLEN] : prod_n[XLEN-1:0];
    quo      = neg_q ? -lo_q : lo_q;
    rmd      = neg_rem_q ? -acc_q : acc_q;
    fix_raw  = div_q ? (rem_q ? rmd : quo) : mul_r;
    fix_res  = word_q ? sext32(fix_raw[31:0], 1'b1) : fix_raw;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    b_d       = b_q;
    word_d    = word_q;
    div_d     = div_q;
    hi_d      = hi_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    tag_d     = tag_q;
    tag_out_d = tag_out_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          word_d    = req_word;
          div_d     = op[2];
          hi_d      = !op[2] && (op[1:0] != 2'b00);
          rem_d     = op[1];
          neg_d     = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          tag_d     = tag_in;
          cnt_d     = '0;
          acc_d     = '0;
          b_d       = mag_b;
          // Word divides shift the 32-bit dividend to the top so its MSB is consumed first.
          lo_d      = (op[2] && req_word) ? (mag_a << WSH) : mag_a;
          if (div_zero || div_ovf) begin
            state_d   = DONE;
            result_d  = fast_res;
            tag_out_d = tag_in;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (div_q) begin
          if (!div_diff[XLEN]) begin
            acc_d = div_diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_sh[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == cnt_last) state_d = FIX;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      FIX: begin
        state_d   = DONE;
        result_d  = fix_res;
        tag_out_d = tag_q;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      word_q    <= 1'b0;
      div_q     <= 1'b0;
      hi_q      <= 1'b0;
      rem_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      tag_out_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      word_q    <= word_d;
      div_q     <= div_d;
      hi_q      <= hi_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      tag_q     <= tag_d;
      tag_out_q <= tag_out_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_ysyx_220066_mul_div_unit.sv
// Scoreboard bench for the multiply/divide unit: a reference model computes results with
// native SV arithmetic; each scenario task checks latency, result, tag and handshake.
`timescale 1ns/1ps
module tb_ysyx_220066_mul_div_unit;

  localparam logic [3:0] OP_MUL = 4'd0, OP_MULH = 4'd1, OP_MULHSU = 4'd2, OP_MULHU = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4, OP_DIVU = 4'd5, OP_REM = 4'd6, OP_REMU = 4'd7;
  localparam logic [3:0] OP_W = 4'd8;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [63:0] src1 = '0, src2 = '0;
  logic [4:0]  tag_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [4:0]  tag_out;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  ysyx_220066_mul_div_unit #(.XLEN(64), .W_EN(1), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .tag_in(tag_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  function automatic bit is_word(input logic [3:0] o);
    return o[3] && (o[2:0] == 3'd0 || o[2]);
  endfunction

  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    logic [31:0]        a32, b32, r32;
    logic [63:0]        r;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0]; sa = a; sb = b;
    r32 = '0; r = '0; p = '0;
    if (is_word(o)) begin
      case (o[2:0])
        3'd0: r32 = a32 * b32;
        3'd4: if (b32 == 0) r32 = '1; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32; else r32 = sa32 / sb32;
        3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        3'd6: if (b32 == 0) r32 = a32; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0; else r32 = sa32 % sb32;
        default: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (o[2:0])
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a; else r = sa / sb;
      3'd5: if (b == 0) r = '1; else r = a / b;
      3'd6: if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0; else r = sa % sb;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  // Drives one request through its accept edge and records the expected result.
  task automatic send(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    exp_t e;
    op = o; src1 = a; src2 = b; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    op = 4'($urandom); tag_in = 5'($urandom);
    e.res = model(o, a, b); e.tag = t;
    sb.push_back(e);
  endtask

  task automatic wait_result(input int max, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    checks++; if (tag_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_tag: got %h expected 0", tag_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [3:0]  ops[6];
    logic [63:0] as[6], bs[6];
    exp_t e; int cyc; bit ok; int lat;
    ops[0] = OP_MUL;        as[0] = 64'd7;                  bs[0] = 64'hFFFF_FFFF_FFFF_FFFD;
    ops[1] = OP_MULHU;      as[1] = '1;                     bs[1] = '1;
    ops[2] = OP_MULH;       as[2] = '1;                     bs[2] = '1;
    ops[3] = OP_MULHSU;     as[3] = '1;                     bs[3] = 64'd2;
    ops[4] = OP_W | OP_MUL; as[4] = 64'h1234_5678_9ABC_DEF0; bs[4] = 64'h0FED_CBA9_8765_4321;
    ops[5] = OP_W | OP_MULH; as[5] = {$urandom, $urandom};   bs[5] = {$urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      send(ops[i], as[i], bs[i], (i == 0) ? 5'd5 : 5'(i + 10));
      lat = is_word(ops[i]) ? 33 : 65;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mul%0d_busy: got in_ready=%b expected 0", i, in_ready); end
      wait_result(200, cyc, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("[TB] FAIL mul%0d_timeout: got no out_valid expected within 200 cycles", i); end
      checks++; if (cyc != lat) begin errors++; $display("[TB] FAIL mul%0d_latency: got %0d expected %0d", i, cyc, lat); end
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL mul%0d_result: got %h expected %h", i, result, e.res); end
      checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL mul%0d_tag: got %h expected %h", i, tag_out, e.tag); end
      release_result();
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops[9];
    logic [63:0] as[9], bs[9];
    exp_t e; int cyc; bit ok; int lat;
    ops[0] = OP_DIV;  as[0] = -64'sd100; bs[0] = 64'd7;
    ops[1] = OP_REM;  as[1] = 64'd7;     bs[1] = -64'sd2;
    ops[2] = OP_DIVU; as[2] = {$urandom, $urandom}; bs[2] = {32'd0, $urandom} | 64'd1;
    ops[3] = OP_REMU; as[3] = {$urandom, $urandom}; bs[3] = {$urandom, $urandom} | 64'd1;
    ops[4] = OP_DIV;  as[4] = {$urandom, $urandom}; bs[4] = {16'd0, 16'($urandom), $urandom} | 64'd1;
    ops[5] = OP_W | OP_DIV;  as[5] = {$urandom, $urandom}; bs[5] = {$urandom, 16'd0, 16'($urandom)} | 64'd1;
    ops[6] = OP_W | OP_DIVU; as[6] = {$urandom, $urandom}; bs[6] = {$urandom, 20'd0, 12'($urandom)} | 64'd1;
    ops[7] = OP_W | OP_REM;  as[7] = 64'h0000_0000_FFFF_FF9C; bs[7] = 64'h0000_0000_0000_0007;
    ops[8] = OP_W | OP_REMU; as[8] = {$urandom, $urandom}; bs[8] = {$urandom, 24'd0, 8'($urandom)} | 64'd1;
    for (int i = 0; i < 9; i++) begin
      send(ops[i], as[i], bs[i], 5'(i + 1));
      lat = is_word(ops[i]) ? 33 : 65;
      wait_result(200, cyc, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("[TB] FAIL div%0d_timeout: got no out_valid expected within 200 cycles", i); end
      checks++; if (cyc != lat) begin errors++; $display("[TB] FAIL div%0d_latency: got %0d expected %0d", i, cyc, lat); end
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL div%0d_result: got %h expected %h", i, result, e.res); end
      checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL div%0d_tag: got %h expected %h", i, tag_out, e.tag); end
      release_result();
    end
  endtask

  task automatic test_fast_path();
    logic [3:0]  ops[6];
    logic [63:0] as[6], bs[6];
    exp_t e; int cyc; bit ok;
    ops[0] = OP_W | OP_DIV;  as[0] = 64'h0000_0000_8000_0000; bs[0] = 64'h0000_0000_FFFF_FFFF;
    ops[1] = OP_W | OP_REM;  as[1] = 64'h0000_0000_8000_0000; bs[1] = 64'h0000_0000_FFFF_FFFF;
    ops[2] = OP_DIVU;        as[2] = 64'h1234;                bs[2] = 64'd0;
    ops[3] = OP_REMU;        as[3] = 64'h1234;                bs[3] = 64'd0;
    ops[4] = OP_DIV;         as[4] = 64'h8000_0000_0000_0000; bs[4] = '1;
    ops[5] = OP_W | OP_REMU; as[5] = 64'hABCD_0000_9000_0000; bs[5] = 64'h1234_5678_0000_0000;
    for (int i = 0; i < 6; i++) begin
      send(ops[i], as[i], bs[i], 5'(i + 20));
      wait_result(10, cyc, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("[TB] FAIL fast%0d_timeout: got no out_valid expected within 10 cycles", i); end
      checks++; if (cyc != 0) begin errors++; $display("[TB] FAIL fast%0d_latency: got %0d extra cycles expected 0", i, cyc); end
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL fast%0d_result: got %h expected %h", i, result, e.res); end
      checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL fast%0d_tag: got %h expected %h", i, tag_out, e.tag); end
      release_result();
    end
  endtask

  task automatic test_hold();
    exp_t e; int cyc; bit ok;
    send(OP_REM, -64'sd7, 64'd2, 5'd9);
    wait_result(200, cyc, ok);
    e = sb[0];
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_timeout: got no out_valid expected within 200 cycles"); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL hold_rem: got %h expected ffffffffffffffff", result); end
    op = OP_MUL; src1 = 64'd3; src2 = 64'd4; tag_in = 5'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL hold_result%0d: got %h expected %h", i, result, e.res); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready%0d: got %b expected 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_out_valid%0d: got %b expected 1", i, out_valid); end
    end
    in_valid = 1'b0;
    void'(sb.pop_front());
    release_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_no_accept: got in_ready=%b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int cyc; bit ok;
    send(OP_DIVU, 64'h55, 64'd0, 5'd3);
    e = sb.pop_front();
    checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", result, e.res); end
    op = OP_MUL; src1 = 64'd123456789; src2 = -64'sd987; tag_in = 5'd30; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.res = model(OP_MUL, 64'd123456789, -64'sd987); e.tag = 5'd30;
    sb.push_back(e);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got in_ready=%b expected 0", in_ready); end
    wait_result(200, cyc, ok);
    e = sb.pop_front();
    checks++; if (cyc != 65) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 65", cyc); end
    checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL b2b_result: got %h expected %h", result, e.res); end
    checks++; if (tag_out !== e.tag) begin errors++; $display("[TB] FAIL b2b_tag: got %h expected %h", tag_out, e.tag); end
    release_result();
  endtask

  task automatic test_flush();
    bit seen;
    send(OP_DIV, 64'd1000, 64'd3, 5'd7);
    void'(sb.pop_back());
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; src1 = 64'd9; src2 = 64'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost: got out_valid after flush expected none"); end
    flush = 1'b1; in_valid = 1'b1; op = OP_DIVU; src1 = 64'd9; src2 = 64'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_accept: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    send(OP_DIVU, 64'd9, 64'd0, 5'd4);
    void'(sb.pop_back());
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_done_setup: got %b expected 1", out_valid); end
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_done: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(OP_DIV, 64'd5000, 64'd7, 5'd17);
    void'(sb.pop_back());
    repeat (28) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 64'd0) begin errors++; $display("[TB] FAIL rstmid_result: got %h expected 0", result); end
    checks++; if (tag_out !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_tag: got %h expected 0", tag_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b expected 1", in_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ghost: got out_valid after reset expected none"); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_mul_div_unit.md
Name: ysyx_220066_mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit: the RV64M companion to the single-cycle combinational ALU in the execute stage.
- Implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the 32-bit W forms.
- Iterative: one bit per cycle, with a valid/ready handshake on both sides and a pipeline flush input.
- Parametrised in datapath width and carries a destination tag through to the result.

Parameters:
- XLEN, 64, datapath width in bits (32 or 64).
- W_EN, 1, enables word-mode (op[3]) handling; must be 0 when XLEN=32.
- TAG_W, 5, width of the pass-through tag (rd index).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  4  op[3]=word; op[2:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1  in  XLEN  rs1 operand.
- src2  in  XLEN  rs2 operand.
- tag_in  in  TAG_W  tag captured with the request.
- flush  in  1  synchronous kill of any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  result value.
- tag_out  out  TAG_W  tag of the request being reported.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out_valid=0, result=0, tag_out=0, counter=0. in_ready=1 while in IDLE, including during reset.
- States: IDLE, CALC, FIX, DONE.
- Accept: in_valid & in_ready & ~flush at rising edge k. Operands, op and tag are latched at that edge.
- Word mode (W_EN=1, op[3]=1, op[2:0] in {0,4,5,6,7}):
  - Operands are taken from bits [31:0], sign- or zero-extended according to signedness. N=32.
  - Final result = sign-extension of its bit 31.
  - op[3]=1 with op[2:0] in 1..3 is treated as op[3]=0.
  - Otherwise N=XLEN.
- Signedness: MUL, MULH, DIV and REM are signed×signed; MULHSU is signed×unsigned; MULHU, DIVU and REMU are unsigned.
- The datapath works on magnitudes. Result negation is applied in FIX.
- Multiply:
  - CALC performs shift-add over N cycles and forms a 2N-bit magnitude product.
  - FIX negates the product if the operand signs differ.
  - MUL returns the low N bits; the MULH variants return the high XLEN bits.
- Divide:
  - CALC performs restoring division over N cycles.
  - FIX negates the quotient if the signs differ, and negates the remainder if the dividend is negative.
- Timing, normal path:
  - IDLE→CALC at edge k; counter counts 0..N-1.
  - CALC→FIX at edge k+N.
  - FIX→DONE at edge k+N+1; result, tag_out and out_valid are registered at that edge.
  - Latency is N+1 cycles (65 for 64-bit ops, 33 for W ops).
- Fast path (IDLE→DONE at edge k, so out_valid is seen in cycle k+1):
  - Divisor==0: DIV/DIVU quotient = all ones; REM/REMU = dividend (width-adjusted, sign-extended in W mode).
  - Signed overflow (dividend = most-negative, divisor = -1, for DIV/REM at the current width): quotient = dividend, remainder = 0.
- DONE:
  - out_valid=1; result and tag_out hold stable until out_ready.
  - out_ready=1 at an edge → IDLE, out_valid=0.
  - No new accept while in DONE (in_ready=0), so there is no back-to-back overlap.
- flush=1 at an edge:
  - Any state → IDLE, and out_valid=0 after the edge.
  - A request presented in the same cycle is not accepted.
  - flush takes priority over out_ready and over accept.
- rst_n asserted mid-operation: immediately IDLE, with all outputs at their reset values. No partial result is ever emitted.
- Inputs src1, src2 and op are ignored outside the accept edge.

Test Plan:
- MUL, src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD), tag=5 → after 65 cycles: out_valid=1, result=0xFFFF_FFFF_FFFF_FFEB, tag_out=5.
- MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → result=0.
- DIVW, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF → fast path in 1 cycle, result=0xFFFF_FFFF_8000_0000. REMW with the same operands → result=0.
- DIVU, src2=0, src1=0x1234 → result=0xFFFF_FFFF_FFFF_FFFF in 1 cycle. REMU with the same operands → result=0x1234.
- REM, src1=-7, src2=2 → result=-1. Hold out_ready=0 for 10 cycles → result stable and in_ready=0. Then out_ready=1 → IDLE and in_ready=1.
- DIV accepted, flush at cycle 20 → no out_valid and in_ready=1 next cycle. Repeat with rst_n pulsed low at cycle 30 → outputs zero immediately.
